hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core; it generates the stall, flush and forwarding controls consumed by the F/D, D/E, E/M and M/W pipeline registers and the operand muxes. Load-use and branch-compare hazards are resolved combinationally. A registered memory-wait FSM freezes the whole pipe while data memory is not ready, with a timeout and a sticky error flag. Saturating stall and flush counters support performance debug.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive not-ready cycles before abort.
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RsD, RtD  in  5  D-stage source registers.
- RsE  in  5  E-stage source register A.
- RtE  in  5  E-stage source register B.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register of each stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable of each stage.
- MemtoRegE, MemtoRegM  in  1  load in E / M.
- BranchD  in  1  branch in D (compare done in D).
- PCSrcD  in  1  branch taken.
- MemReqM  in  1  load or store in M.
- MemReadyM  in  1  data memory completes this cycle.
- StallF, StallD, StallE, StallM, StallW  out  1  hold the stage register.
- FlushD, FlushE  out  1  clear the F/D and D/E registers.
- ForwardAE, ForwardBE  out  2  00 = RF, 01 = W result, 10 = M ALU result.
- ForwardAD, ForwardBD  out  1  forward M ALU result to the D comparator.
- mem_err  out  1  sticky timeout flag.
- stall_cycles, flush_count  out  CNT_W  performance counters.

## Operation
- A match on register 0 never counts: every compare requires the destination to be ≠ 0.
- ForwardAE = 10 if RegWriteM & WriteRegM==RsE. Else 01 if RegWriteW & WriteRegW==RsE. Else 00. ForwardBE is the same using RtE.
- ForwardAD = RegWriteM & WriteRegM==RsD. ForwardBD is the same using RtD.
- lwstall = MemtoRegE & RegWriteE & WriteRegE∈{RsD,RtD}.
- branchstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- hazstall = lwstall | branchstall.
- memwait = (state≠ERR) & MemReqM & ~MemReadyM & ~(state==WAIT & cnt==MEM_TIMEOUT).
- StallF = StallD = hazstall | memwait.
- StallE = StallM = StallW = memwait. The whole pipe freezes, so W forwarding stays valid.
- FlushE = hazstall & ~memwait.
- FlushD = PCSrcD & ~StallD.
- memwait has priority: no flush is issued during a freeze.
- FSM states: RUN, WAIT, ERR. Wait counter cnt is sized to hold MEM_TIMEOUT.
  - RUN: MemReqM & ~MemReadyM → WAIT, cnt←1.
  - WAIT: MemReadyM → RUN. Else cnt==MEM_TIMEOUT → ERR, mem_err←1. Else cnt←cnt+1.
  - ERR: stays in ERR until reset. memwait is forced to 0; hazard and forwarding logic keep working.
- stall_cycles increments every cycle StallF=1. flush_count increments every cycle FlushD|FlushE=1. Both saturate at all-ones.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the registered state, so they are valid before the same rising edge that pipeline registers sample them.
- FSM, cnt, mem_err and counters update on the rising clk edge.
- Reset (asynchronous, rst_n=0) gives: state=RUN, cnt=0, mem_err=0, stall_cycles=0, flush_count=0.
- During reset, combinational outputs follow the inputs with state=RUN.
- Reset mid-WAIT returns to RUN immediately; the next cycle with MemReqM & ~MemReadyM re-stalls.
- A load-use stall lasts exactly one cycle: the next cycle the load is in M, FlushE has inserted a bubble, and ForwardAE/BE selects 01 from W one cycle later.
- MemReadyM high in the same cycle as MemReqM: no stall, FSM stays in RUN.
- MemReadyM arrives on the cycle cnt==MEM_TIMEOUT: ready wins, go to RUN, no error.

## Test plan
- Back-to-back dependency: add $3 in M, sub using $3 as RsE → ForwardAE=10. Same with $3 in W only → 01. Dest $0 → 00.
- Load-use: lw $5 in E (MemtoRegE=1), RsD=5 → StallF=StallD=FlushE=1 for one cycle, FlushD=0, stall_cycles=1, flush_count=1.
- Branch: BranchD=1, RtD=7, RegWriteE=1, WriteRegE=7 → stall. Next cycle WriteRegM=7 (not load) → ForwardBD=1, no stall. With PCSrcD=1 → FlushD=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → all five stalls high 3 cycles, FlushE=0 even with lwstall pending, then state returns to RUN.
- Timeout (MEM_TIMEOUT=4): ready held 0 → freeze for 4 cycles, then mem_err=1, stalls drop, state ERR persists until rst_n pulse clears everything.
- Counter saturation (CNT_W=4): hold load-use stall 20 cycles → stall_cycles=15 and stays there.

Source files
------------

// File: rtl/hazard_unit_if.sv
//------------------------------------------------------------------------------
// Module   : hazard_unit_if
// Brief    : Bundle of pipeline-side hazard inputs and the stall / flush /
//            forward controls returned by the hazard unit.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_unit_if #(
   parameter int CNT_W = 32
);
   // Register specifiers of the D, E, M and W stages
   logic [4:0]       RsD;
   logic [4:0]       RtD;
   logic [4:0]       RsE;
   logic [4:0]       RtE;
   logic [4:0]       WriteRegE;
   logic [4:0]       WriteRegM;
   logic [4:0]       WriteRegW;

   // Per-stage control bits
   logic             RegWriteE;
   logic             RegWriteM;
   logic             RegWriteW;
   logic             MemtoRegE;
   logic             MemtoRegM;
   logic             BranchD;
   logic             PCSrcD;
   logic             MemReqM;
   logic             MemReadyM;

   // Pipeline register controls
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             StallW;
   logic             FlushD;
   logic             FlushE;

   // Operand mux selects
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             ForwardAD;
   logic             ForwardBD;

   // Status and performance counters
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   // Pipeline side: drives stage information, consumes controls
   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
      output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
      output BranchD, PCSrcD, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
      input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
      input  mem_err, stall_cycles, flush_count
   );

   // Hazard unit side
   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
      input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
      input  BranchD, PCSrcD, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
      output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
      output mem_err, stall_cycles, flush_count
   );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
//------------------------------------------------------------------------------
// Module   : hazard_unit
// Brief    : Five-stage MIPS hazard controller. Combinational load-use and
//            branch-compare stall detection, operand forwarding selects, a
//            memory-wait FSM that freezes the whole pipe with timeout and a
//            sticky error flag, plus saturating stall / flush counters.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   hazard_unit_if.slave  bus
);

   // Wait counter must be able to hold the value MEM_TIMEOUT itself
   localparam int                     c_WCNT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_WCNT_W-1:0]    c_TIMEOUT = c_WCNT_W'(MEM_TIMEOUT);
   localparam logic [c_WCNT_W-1:0]    c_WONE    = c_WCNT_W'(1);
   localparam logic [CNT_W-1:0]       c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]       c_CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_WCNT_W-1:0] r_cnt;
   logic [c_WCNT_W-1:0] w_cnt_nxt;
   logic                r_mem_err;
   logic                w_mem_err_nxt;
   logic [CNT_W-1:0]    r_stall_cycles;
   logic [CNT_W-1:0]    r_flush_count;

   logic [1:0]          w_fwd_ae;
   logic [1:0]          w_fwd_be;
   logic                w_fwd_ad;
   logic                w_fwd_bd;
   logic                w_dep_e;       // E destination feeds a D source
   logic                w_dep_m;       // M destination feeds a D source
   logic                w_lwstall;
   logic                w_branchstall;
   logic                w_hazstall;
   logic                w_timeout;
   logic                w_memwait;
   logic                w_stall_fd;
   logic                w_flush_d;
   logic                w_flush_e;

   // E-stage and D-comparator forwarding; register 0 is never a valid source
   always_comb begin
      w_fwd_ae = 2'b00;
      w_fwd_be = 2'b00;
      if (bus.RegWriteM && (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RsE)) begin
         w_fwd_ae = 2'b10;
      end else if (bus.RegWriteW && (bus.WriteRegW != 5'd0) && (bus.WriteRegW == bus.RsE)) begin
         w_fwd_ae = 2'b01;
      end
      if (bus.RegWriteM && (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RtE)) begin
         w_fwd_be = 2'b10;
      end else if (bus.RegWriteW && (bus.WriteRegW != 5'd0) && (bus.WriteRegW == bus.RtE)) begin
         w_fwd_be = 2'b01;
      end
      w_fwd_ad = bus.RegWriteM && (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RsD);
      w_fwd_bd = bus.RegWriteM && (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RtD);
   end

   // Load-use and branch-compare hazard detection
   always_comb begin
      w_dep_e = (bus.WriteRegE != 5'd0) &&
                ((bus.WriteRegE == bus.RsD) || (bus.WriteRegE == bus.RtD));
      w_dep_m = (bus.WriteRegM != 5'd0) &&
                ((bus.WriteRegM == bus.RsD) || (bus.WriteRegM == bus.RtD));
      w_lwstall     = bus.MemtoRegE && bus.RegWriteE && w_dep_e;
      // The D comparator can take an M ALU result by forwarding, but not
      // a value still being computed in E or a load still in M.
      w_branchstall = bus.BranchD &&
                      ((bus.RegWriteE && w_dep_e) || (bus.MemtoRegM && w_dep_m));
      w_hazstall    = w_lwstall || w_branchstall;
   end

   // Memory freeze and the resulting stall / flush controls
   always_comb begin
      w_timeout  = (r_state == S_WAIT) && (r_cnt == c_TIMEOUT);
      // On the timeout cycle the freeze is released even though memory is
      // still not ready; ERR leaves the pipe running permanently.
      w_memwait  = (r_state != S_ERR) && bus.MemReqM && !bus.MemReadyM && !w_timeout;
      w_stall_fd = w_hazstall || w_memwait;
      // A frozen pipe must not lose instructions, so freezes beat flushes
      w_flush_e  = w_hazstall && !w_memwait;
      w_flush_d  = bus.PCSrcD && !w_stall_fd;
   end

   // Memory-wait FSM next state
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_mem_err_nxt = r_mem_err;
      case (r_state)
         S_RUN: begin
            if (bus.MemReqM && !bus.MemReadyM) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = c_WONE;
            end
         end
         S_WAIT: begin
            // Ready arriving on the timeout cycle still completes normally
            if (bus.MemReadyM) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_TIMEOUT) begin
               w_state_nxt   = S_ERR;
               w_cnt_nxt     = '0;
               w_mem_err_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_WONE;
            end
         end
         S_ERR: begin
            w_state_nxt = S_ERR;
         end
         default: begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Memory-wait FSM state, wait counter and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RUN;
         r_cnt     <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mem_err <= w_mem_err_nxt;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (w_stall_fd && (r_stall_cycles != c_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
         end
         if ((w_flush_d || w_flush_e) && (r_flush_count != c_CNT_MAX)) begin
            r_flush_count <= r_flush_count + c_CNT_ONE;
         end
      end
   end

   assign bus.StallF       = w_stall_fd;
   assign bus.StallD       = w_stall_fd;
   assign bus.StallE       = w_memwait;
   assign bus.StallM       = w_memwait;
   assign bus.StallW       = w_memwait;
   assign bus.FlushD       = w_flush_d;
   assign bus.FlushE       = w_flush_e;
   assign bus.ForwardAE    = w_fwd_ae;
   assign bus.ForwardBE    = w_fwd_be;
   assign bus.ForwardAD    = w_fwd_ad;
   assign bus.ForwardBD    = w_fwd_bd;
   assign bus.mem_err      = r_mem_err;
   assign bus.stall_cycles = r_stall_cycles;
   assign bus.flush_count  = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_unit
// Brief    : Randomized scoreboard bench for hazard_unit with a behavioural
//            reference model of the hazard rules and memory timeout.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;

   localparam int c_T     = 4;
   localparam int c_CNT_W = 4;
   localparam int c_SAT   = (1 << c_CNT_W) - 1;

   typedef struct {
      logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
      logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
      logic       BranchD, PCSrcD, MemReqM, MemReadyM;
   } in_t;

   typedef struct {
      int sF, sD, sE, sM, sW, fD, fE, fAE, fBE, fAD, fBD, err, sc, fc;
   } exp_t;

   logic clk;
   logic rst_n;

   hazard_unit_if #(.CNT_W(c_CNT_W)) bus ();

   hazard_unit #(.MEM_TIMEOUT(c_T), .CNT_W(c_CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard
   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state: number of not-ready cycles already waited in the
   // current access, sticky error, counters, and the previous cycle's view.
   int   m_waited;
   bit   m_err;
   int   m_sc, m_fc;
   in_t  m_prev_in;
   exp_t m_prev_exp;
   bit   m_prev_rst;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   function automatic int fwd_e(input in_t v, input logic [4:0] src);
      if (v.RegWriteM && v.WriteRegM != 0 && v.WriteRegM == src) return 2;
      if (v.RegWriteW && v.WriteRegW != 0 && v.WriteRegW == src) return 1;
      return 0;
   endfunction

   function automatic bit reads(input logic [4:0] dst, input in_t v);
      return (dst != 0) && (dst == v.RsD || dst == v.RtD);
   endfunction

   function automatic exp_t predict(input in_t v);
      exp_t e;
      bit   lw, br, haz, freeze;
      lw     = v.MemtoRegE && v.RegWriteE && reads(v.WriteRegE, v);
      br     = v.BranchD && ((v.RegWriteE && reads(v.WriteRegE, v)) ||
                             (v.MemtoRegM && reads(v.WriteRegM, v)));
      haz    = lw || br;
      // Freeze while memory is busy, unless the timeout budget is used up
      freeze = !m_err && v.MemReqM && !v.MemReadyM && (m_waited != c_T);
      e.sF  = int'(haz || freeze);
      e.sD  = e.sF;
      e.sE  = int'(freeze);
      e.sM  = e.sE;
      e.sW  = e.sE;
      e.fE  = int'(haz && !freeze);
      e.fD  = int'(v.PCSrcD && !(haz || freeze));
      e.fAE = fwd_e(v, v.RsE);
      e.fBE = fwd_e(v, v.RtE);
      e.fAD = int'(v.RegWriteM && v.WriteRegM != 0 && v.WriteRegM == v.RsD);
      e.fBD = int'(v.RegWriteM && v.WriteRegM != 0 && v.WriteRegM == v.RtD);
      e.err = int'(m_err);
      e.sc  = m_sc;
      e.fc  = m_fc;
      return e;
   endfunction

   // Advance the model across one rising edge using last cycle's activity
   task automatic model_edge();
      if (m_prev_rst) return;
      if (m_prev_exp.sF != 0 && m_sc < c_SAT) m_sc++;
      if ((m_prev_exp.fD != 0 || m_prev_exp.fE != 0) && m_fc < c_SAT) m_fc++;
      if (!m_err) begin
         if (m_waited == 0) begin
            if (m_prev_in.MemReqM && !m_prev_in.MemReadyM) m_waited = 1;
         end else if (m_prev_in.MemReadyM) begin
            m_waited = 0;
         end else if (m_waited == c_T) begin
            m_err    = 1'b1;
            m_waited = 0;
         end else begin
            m_waited++;
         end
      end
   endtask

   task automatic drive(input in_t v);
      bus.RsD       = v.RsD;       bus.RtD       = v.RtD;
      bus.RsE       = v.RsE;       bus.RtE       = v.RtE;
      bus.WriteRegE = v.WriteRegE; bus.WriteRegM = v.WriteRegM;
      bus.WriteRegW = v.WriteRegW;
      bus.RegWriteE = v.RegWriteE; bus.RegWriteM = v.RegWriteM;
      bus.RegWriteW = v.RegWriteW; bus.MemtoRegE = v.MemtoRegE;
      bus.MemtoRegM = v.MemtoRegM; bus.BranchD   = v.BranchD;
      bus.PCSrcD    = v.PCSrcD;    bus.MemReqM   = v.MemReqM;
      bus.MemReadyM = v.MemReadyM;
   endtask

   // One clock cycle of stimulus; expected response goes to the scoreboard
   task automatic step(input in_t v, input bit rst);
      exp_t e;
      @(posedge clk);
      #1;
      model_edge();
      rst_n = !rst;
      if (rst) begin
         m_waited = 0;
         m_err    = 1'b0;
         m_sc     = 0;
         m_fc     = 0;
      end
      drive(v);
      e = predict(v);
      q.push_back(e);
      m_prev_in  = v;
      m_prev_exp = e;
      m_prev_rst = rst;
   endtask

   function automatic in_t rand_vec(input int req_pct, input int rdy_pct);
      in_t v;
      v.RsD       = 5'($urandom_range(0, 3));
      v.RtD       = 5'($urandom_range(0, 3));
      v.RsE       = 5'($urandom_range(0, 3));
      v.RtE       = 5'($urandom_range(0, 3));
      v.WriteRegE = 5'($urandom_range(0, 3));
      v.WriteRegM = 5'($urandom_range(0, 3));
      v.WriteRegW = 5'($urandom_range(0, 3));
      v.RegWriteE = 1'($urandom_range(0, 1));
      v.RegWriteM = 1'($urandom_range(0, 1));
      v.RegWriteW = 1'($urandom_range(0, 1));
      v.MemtoRegE = 1'($urandom_range(0, 1));
      v.MemtoRegM = 1'($urandom_range(0, 1));
      v.BranchD   = 1'($urandom_range(0, 1));
      v.PCSrcD    = 1'($urandom_range(0, 1));
      v.MemReqM   = 1'($urandom_range(0, 99) < req_pct);
      v.MemReadyM = 1'($urandom_range(0, 99) < rdy_pct);
      return v;
   endfunction

   // Monitor: outputs are valid every cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("StallF",       int'(bus.StallF),       e.sF);
            check("StallD",       int'(bus.StallD),       e.sD);
            check("StallE",       int'(bus.StallE),       e.sE);
            check("StallM",       int'(bus.StallM),       e.sM);
            check("StallW",       int'(bus.StallW),       e.sW);
            check("FlushD",       int'(bus.FlushD),       e.fD);
            check("FlushE",       int'(bus.FlushE),       e.fE);
            check("ForwardAE",    int'(bus.ForwardAE),    e.fAE);
            check("ForwardBE",    int'(bus.ForwardBE),    e.fBE);
            check("ForwardAD",    int'(bus.ForwardAD),    e.fAD);
            check("ForwardBD",    int'(bus.ForwardBD),    e.fBD);
            check("mem_err",      int'(bus.mem_err),      e.err);
            check("stall_cycles", int'(bus.stall_cycles), e.sc);
            check("flush_count",  int'(bus.flush_count),  e.fc);
         end
      end
   end

   initial begin
      in_t v;
      m_waited   = 0;
      m_err      = 1'b0;
      m_sc       = 0;
      m_fc       = 0;
      m_prev_rst = 1'b1;
      rst_n      = 1'b0;
      v          = rand_vec(0, 0);
      drive(v);

      // Reset with random inputs: combinational outputs follow inputs
      repeat (3) step(rand_vec(50, 50), 1'b1);

      // Random traffic with occasional reset pulses
      for (int i = 0; i < 400; i++) begin
         step(rand_vec(40, 45), ($urandom_range(0, 99) < 3));
      end

      // Held load-use hazard: counters must saturate
      step(rand_vec(0, 0), 1'b1);
      for (int i = 0; i < 20; i++) begin
         v           = rand_vec(0, 0);
         v.RsD       = 5'd5;
         v.WriteRegE = 5'd5;
         v.RegWriteE = 1'b1;
         v.MemtoRegE = 1'b1;
         step(v, 1'b0);
      end

      // Memory never ready: freeze, timeout, sticky error
      step(rand_vec(0, 0), 1'b1);
      for (int i = 0; i < 10; i++) begin
         v           = rand_vec(100, 0);
         step(v, 1'b0);
      end

      // Ready landing exactly on the timeout cycle
      step(rand_vec(0, 0), 1'b1);
      for (int i = 0; i < 6; i++) begin
         v           = rand_vec(100, 0);
         v.MemReadyM = (i == c_T);
         step(v, 1'b0);
      end

      // Mostly-ready random traffic after a reset
      step(rand_vec(0, 0), 1'b1);
      for (int i = 0; i < 300; i++) begin
         step(rand_vec(50, 70), 1'b0);
      end

      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
